frontend_fetch_sequencer: RTL and testbench

Fetch controller for the pipeline frontend. It sequences instruction-memory requests one at a time and statically predicts the next PC from predecode: branches and j/jal are taken, everything else falls through. Fetched {pc, instr} pairs are buffered in a small FIFO toward decode. On a redirect (miss/rpc) from the branch-resolution logic it flushes the FIFO, discards any in-flight response, and refetches from rpc.

---
 rtl/frontend_fetch_sequencer.sv | 143 ++++++++++++++
 tb/tb_frontend_fetch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frontend_fetch_sequencer.sv
// Frontend fetch controller: one outstanding imem request, static next-PC
// prediction from predecode, and a small {pc, instr} FIFO toward decode.
module frontend_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        miss,
   input  logic [31:0] rpc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_FULL} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        drop_q, drop_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;

   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] instr_mem [DEPTH];

   logic        push, pop, req_fire, full_d;
   logic [5:0]  op;
   logic [31:0] pc4, br_off, pred_pc;

   assign out_valid      = (wr_ptr_q != rd_ptr_q);
   assign out_pc         = pc_mem[rd_ptr_q[AW-1:0]];
   assign out_instr      = instr_mem[rd_ptr_q[AW-1:0]];
   assign imem_req_valid = resetn && (state_q == S_REQ) && !miss;
   assign imem_addr      = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A redirect suppresses both FIFO ports in the cycle it is seen.
   assign pop  = out_valid && out_ready && !miss;
   assign push = (state_q == S_WAIT) && imem_resp_valid && !drop_q && !miss;

   always_comb begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      if (miss) begin
         rd_ptr_d = wr_ptr_q;
      end
      full_d = ((wr_ptr_d ^ rd_ptr_d) == FULL_XOR);
   end

   assign op     = imem_resp_data[31:26];
   assign pc4    = req_pc_q + 32'd4;
   assign br_off = {{14{imem_resp_data[15]}}, imem_resp_data[15:0], 2'b00};

   always_comb begin
      case (op)
         6'b000100, 6'b000101: pred_pc = pc4 + br_off;
         6'b000010, 6'b000011: pred_pc = {pc4[31:28], imem_resp_data[25:0], 2'b00};
         default:              pred_pc = pc4;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      drop_d     = drop_q;
      if (miss) begin
         fetch_pc_d = rpc;
         case (state_q)
            S_WAIT: begin
               // With no response yet, the in-flight one must be swallowed later.
               if (imem_resp_valid) begin
                  state_d = S_REQ;
                  drop_d  = 1'b0;
               end else begin
                  drop_d  = 1'b1;
               end
            end
            S_FULL:  state_d = S_REQ;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (req_fire) begin
                  req_pc_d = fetch_pc_q;
                  state_d  = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_resp_valid) begin
                  if (drop_q) begin
                     drop_d  = 1'b0;
                     state_d = S_REQ;
                  end else begin
                     fetch_pc_d = pred_pc;
                     state_d    = full_d ? S_FULL : S_REQ;
                  end
               end
            end
            S_FULL: begin
               if (!full_d) state_d = S_REQ;
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_REQ;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         drop_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         drop_q     <= drop_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q[AW-1:0]]    <= req_pc_q;
         instr_mem[wr_ptr_q[AW-1:0]] <= imem_resp_data;
      end
   end
endmodule

// File: tb/tb_frontend_fetch_sequencer.sv
// Self-checking bench for frontend_fetch_sequencer: predecode vector table,
// FIFO scoreboard, and hand-written redirect / full / reset sequences.
module tb_frontend_fetch_sequencer;
   logic        clk = 1'b0;
   logic        resetn;
   logic        miss;
   logic [31:0] rpc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;

   always #5 clk = ~clk;

   frontend_fetch_sequencer #(.RESET_PC(32'h0000_3000), .DEPTH(4)) dut (
      .clk(clk), .resetn(resetn), .miss(miss), .rpc(rpc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } sb_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] next_pc;
   } vec_t;

   sb_t  sb[$];
   vec_t vecs[10];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: compare every entry decode actually consumes.
   always @(negedge clk) begin : monitor
      sb_t e;
      if (resetn && out_valid && out_ready && !miss) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow actual_pc=%h required=none", out_pc);
         end else begin
            e = sb.pop_front();
            chk("out_pc", out_pc, e.pc);
            chk("out_instr", out_instr, e.instr);
            $display("pop pc=%h instr=%h", out_pc, out_instr);
         end
      end
   end

   task automatic wait_req();
      int n = 0;
      while (!imem_req_valid && n < 20) begin
         tick();
         n++;
      end
      chk("req_valid_wait", 32'(imem_req_valid), 32'd1);
   endtask

   task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input bit pop_on_resp);
      logic saved;
      wait_req();
      chk("imem_addr", imem_addr, addr);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      chk("req_idle_in_wait", 32'(imem_req_valid), 32'd0);
      saved           = out_ready;
      out_ready       = saved | pop_on_resp;
      imem_resp_valid = 1'b1;
      imem_resp_data  = data;
      sb.push_back('{pc: addr, instr: data});
      tick();
      imem_resp_valid = 1'b0;
      out_ready       = saved;
      chk("out_valid_after_resp", 32'(out_valid), 32'd1);
      $display("fetch pc=%h instr=%h", addr, data);
   endtask

   initial begin
      vecs[0] = '{pc: 32'h0000_3000, instr: 32'h0000_0000, next_pc: 32'h0000_3004};
      vecs[1] = '{pc: 32'h0000_3004, instr: 32'h1000_FFFE, next_pc: 32'h0000_3000};
      vecs[2] = '{pc: 32'h0000_3000, instr: 32'h0800_0C40, next_pc: 32'h0000_3100};
      vecs[3] = '{pc: 32'h0000_3100, instr: 32'h1400_0010, next_pc: 32'h0000_3144};
      vecs[4] = '{pc: 32'h0000_3144, instr: 32'h0C00_0100, next_pc: 32'h0000_0400};
      vecs[5] = '{pc: 32'h0000_0400, instr: 32'h03E0_0008, next_pc: 32'h0000_0404};
      vecs[6] = '{pc: 32'h0000_0404, instr: 32'h8C22_0000, next_pc: 32'h0000_0408};
      vecs[7] = '{pc: 32'h0000_0408, instr: 32'h1000_7FFF, next_pc: 32'h0002_0408};
      vecs[8] = '{pc: 32'h0002_0408, instr: 32'h1000_8000, next_pc: 32'h0000_040C};
      vecs[9] = '{pc: 32'h0000_040C, instr: 32'h0000_0000, next_pc: 32'h0000_0410};

      resetn = 1'b0; miss = 1'b0; rpc = '0; imem_req_ready = 1'b0;
      imem_resp_valid = 1'b0; imem_resp_data = '0; out_ready = 1'b0;
      tick();
      tick();
      chk("reset_req_valid", 32'(imem_req_valid), 32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      resetn = 1'b1;
      #1;
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_addr, 32'h0000_3000);

      // Predecode table: each response steers the following request address.
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         fetch_one(vecs[i].pc, vecs[i].instr, 1'b1);
         wait_req();
         chk("next_pc", imem_addr, vecs[i].next_pc);
      end
      tick();
      chk("table_drained", 32'(out_valid), 32'd0);
      chk("table_sb_empty", 32'(sb.size()), 32'd0);

      // Fill to DEPTH, stall, single pop, push+pop, refill, drain.
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         fetch_one(32'h0000_0410 + 32'(i*4), 32'h2000_0000 + 32'(i), 1'b0);
      end
      tick();
      tick();
      chk("full_no_req", 32'(imem_req_valid), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      chk("resume_req_valid", 32'(imem_req_valid), 32'd1);
      chk("resume_req_addr", imem_addr, 32'h0000_0420);
      fetch_one(32'h0000_0420, 32'h2000_0004, 1'b1);
      chk("pushpop_not_full", 32'(imem_req_valid), 32'd1);
      chk("pushpop_addr", imem_addr, 32'h0000_0424);
      fetch_one(32'h0000_0424, 32'h2000_0005, 1'b0);
      tick();
      chk("refull_no_req", 32'(imem_req_valid), 32'd0);
      out_ready = 1'b1;
      repeat (5) tick();
      out_ready = 1'b0;
      #1;
      chk("drain_empty", 32'(out_valid), 32'd0);
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);

      // Back-to-back misses while waiting; late response must be dropped.
      wait_req();
      chk("pre_miss_addr", imem_addr, 32'h0000_0428);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      miss = 1'b1; rpc = 32'h0000_5000;
      tick();
      rpc = 32'h0000_4000;
      tick();
      miss = 1'b0;
      #1;
      chk("drop_wait_no_req", 32'(imem_req_valid), 32'd0);
      tick();
      imem_resp_valid = 1'b1; imem_resp_data = 32'h0800_0000;
      tick();
      imem_resp_valid = 1'b0;
      #1;
      chk("dropped_no_out", 32'(out_valid), 32'd0);
      chk("redirect_req_valid", 32'(imem_req_valid), 32'd1);
      chk("redirect_req_addr", imem_addr, 32'h0000_4000);
      $display("redirect rpc=4000 dropped stale response");

      // Miss together with the response.
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0000;
      miss = 1'b1; rpc = 32'h0000_6000;
      tick();
      imem_resp_valid = 1'b0; miss = 1'b0;
      #1;
      chk("miss_resp_no_out", 32'(out_valid), 32'd0);
      chk("miss_resp_req_valid", 32'(imem_req_valid), 32'd1);
      chk("miss_resp_req_addr", imem_addr, 32'h0000_6000);
      $display("redirect rpc=6000 with coincident response");
      fetch_one(32'h0000_6000, 32'h2001_0005, 1'b1);
      fetch_one(32'h0000_6004, 32'h2001_0006, 1'b0);
      fetch_one(32'h0000_6008, 32'h2001_0007, 1'b0);

      // Miss with 3 queued, concurrent pop, and request handshake offered.
      wait_req();
      chk("pre_flush_addr", imem_addr, 32'h0000_600C);
      out_ready = 1'b1; imem_req_ready = 1'b1; miss = 1'b1; rpc = 32'h0000_7000;
      #1;
      chk("miss_blocks_req", 32'(imem_req_valid), 32'd0);
      tick();
      sb.delete();
      miss = 1'b0; out_ready = 1'b0; imem_req_ready = 1'b0;
      #1;
      chk("flush_empty", 32'(out_valid), 32'd0);
      chk("flush_req_valid", 32'(imem_req_valid), 32'd1);
      chk("flush_req_addr", imem_addr, 32'h0000_7000);
      $display("flush rpc=7000");

      // Asynchronous reset mid-S_WAIT with 2 entries queued.
      fetch_one(32'h0000_7000, 32'h0000_0000, 1'b0);
      fetch_one(32'h0000_7004, 32'h0000_0000, 1'b0);
      wait_req();
      chk("pre_reset_addr", imem_addr, 32'h0000_7008);
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      resetn = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      sb.delete();
      tick();
      tick();
      resetn = 1'b1;
      #1;
      chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
      chk("post_rst_req_addr", imem_addr, 32'h0000_3000);
      $display("reset mid-wait, refetch 3000");
      fetch_one(32'h0000_3000, 32'h0000_0000, 1'b0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      chk("final_sb_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
